uart_tx_ctrl: RTL and testbench

Transmit-side controller for the SOC serial port: accepts bytes from the CPU's memory-mapped I/O write path, buffers them in a small FIFO, and sequences each byte onto `TXD` as an 8N1 frame paced by an internal baud counter. It sits between the I/O decode logic and the `TXD` pin. It gives firmware a non-blocking byte write and a busy/level status word to poll.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_ctrl_if.sv | 35 +++
 rtl/uart_tx_fifo.sv | 61 ++++++
 rtl/uart_tx_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the serial transmit path.
package uart_pkg;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// CPU-side write path and status of the serial transmitter.
interface uart_tx_ctrl_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) ();

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                      wr_en;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      wr_ready;
  logic [LEVEL_W-1:0]        level;
  logic                      busy;
  logic                      ovf;

  modport master (
    output wr_en,
    output wr_data,
    input  wr_ready,
    input  level,
    input  busy,
    input  ovf
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output wr_ready,
    output level,
    output busy,
    output ovf
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO; the head is readable combinationally so the
// transmitter can load it on the same edge it pops.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level_reg == (AW+1)'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// 8N1 transmitter: buffers CPU writes and serialises them onto TXD,
// chaining frames back to back while the FIFO holds data.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           CLK,
  input  logic           RESETN,
  uart_tx_ctrl_if.slave  bus,
  output logic           TXD
);

  localparam int                 BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam int                 LEVEL_W   = $clog2(FIFO_DEPTH) + 1;

  uart_state_e               state_reg, state_next;
  logic [BAUD_W-1:0]         baud_cnt_reg, baud_cnt_next;
  logic [2:0]                bit_cnt_reg, bit_cnt_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic                      txd_reg, txd_next;
  logic                      ovf_reg, ovf_next;

  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic [LEVEL_W-1:0]        fifo_level;
  logic                      baud_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETN),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign baud_done    = (baud_cnt_reg == BAUD_LAST);
  assign bus.wr_ready = !fifo_full;
  assign bus.level    = fifo_level;
  assign bus.busy     = (state_reg != IDLE) || (fifo_level != '0);
  assign bus.ovf      = ovf_reg;
  assign TXD          = txd_reg;

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg + 1'b1;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    fifo_pop      = 1'b0;
    ovf_next      = ovf_reg | (bus.wr_en & fifo_full);

    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = fifo_data;
          bit_cnt_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          state_next    = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          shift_next    = shift_reg >> 1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      STOP: begin
        // Chain the next frame directly from the last stop cycle.
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        baud_cnt_next = '0;
      end
    endcase

    // TXD is registered from the next state so it lines up with the FSM.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      txd_reg      <= txd_next;
      ovf_reg      <= ovf_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: waveform-queue reference model,
// table-driven fill/overflow vectors and directed frame-timing sequences.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = UART_FRAME_BITS * CPB;

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;
  logic TXD;

  uart_tx_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus),
    .TXD    (TXD)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes waiting, and the TXD level for each cycle still
  // to be shown (head = current cycle).
  logic [7:0] m_q[$];
  bit         m_wave[$];
  bit         m_ovf;
  bit         txd_log[$];

  typedef struct {
    logic       we;
    logic [7:0] data;
    logic [2:0] exp_level;
    logic       exp_ovf;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wave.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] d);
    int  pre;
    bit  accept;
    logic [7:0] b;
    pre    = m_q.size();
    accept = we && (pre < DEPTH);
    if (we && !accept) m_ovf = 1'b1;
    if (m_wave.size() > 0) void'(m_wave.pop_front());
    if (m_wave.size() == 0 && pre > 0) begin
      b = m_q.pop_front();
      for (int j = 0; j < CPB; j++) m_wave.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < CPB; j++) m_wave.push_back(b[k]);
      for (int j = 0; j < CPB; j++) m_wave.push_back(1'b1);
    end
    if (accept) m_q.push_back(d);
  endtask

  task automatic compare_model();
    logic exp_txd;
    exp_txd = (m_wave.size() > 0) ? m_wave[0] : 1'b1;
    check("model_txd",   TXD,          exp_txd);
    check("model_level", bus.level,    m_q.size());
    check("model_busy",  bus.busy,     (m_wave.size() > 0) || (m_q.size() > 0));
    check("model_ready", bus.wr_ready, m_q.size() < DEPTH);
    check("model_ovf",   bus.ovf,      m_ovf);
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    bus.wr_en   = we;
    bus.wr_data = d;
    @(posedge CLK);
    model_edge(we, d);
    #1;
    compare_model();
    txd_log.push_back(TXD);
    bus.wr_en = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Compare one logged frame (LSB-first bit list incl. start/stop).
  task automatic check_frame(input string name, input int base, input logic [9:0] bits);
    logic [3:0] got;
    for (int b = 0; b < UART_FRAME_BITS; b++) begin
      for (int j = 0; j < CPB; j++) got[j] = txd_log[base + b*CPB + j];
      check($sformatf("%s_bit%0d", name, b), got, {4{bits[b]}});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && (m_q.size() != 0 || m_wave.size() != 0); i++)
      step(1'b0, 8'h00);
    check("drain_busy", bus.busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b3c;

    vecs[0] = '{1'b1, 8'h01, 3'd1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h02, 3'd1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h03, 3'd2, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h04, 3'd3, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h05, 3'd4, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h06, 3'd4, 1'b1, 1'b0};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    model_reset();

    // Reset held for three cycles.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_txd_held", TXD, 1'b1);
    RESETN = 1'b1;
    @(negedge CLK);
    check("rst_txd",   TXD,          1'b1);
    check("rst_busy",  bus.busy,     1'b0);
    check("rst_level", bus.level,    3'd0);
    check("rst_ready", bus.wr_ready, 1'b1);
    check("rst_ovf",   bus.ovf,      1'b0);
    @(posedge CLK);
    #1;

    // Single byte 0xA5: start at k+1, 40 cycles, busy drops one edge later.
    txd_log.delete();
    step(1'b1, 8'hA5);
    check("a5_txd_at_k", txd_log[0], 1'b1);
    idle_steps(FRAME);
    check("a5_txd_fall", txd_log[1], 1'b0);
    check_frame("a5", 1, 10'b1101001010);
    check("a5_busy_last_stop", bus.busy, 1'b1);
    step(1'b0, 8'h00);
    check("a5_busy_fall", bus.busy, 1'b0);
    $display("txn a5: single frame done");

    // Six back-to-back writes: fill, overflow, five contiguous frames.
    txd_log.delete();
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].we, vecs[i].data);
      check($sformatf("fill%0d_level", i), bus.level,    vecs[i].exp_level);
      check($sformatf("fill%0d_ovf", i),   bus.ovf,      vecs[i].exp_ovf);
      check($sformatf("fill%0d_ready", i), bus.wr_ready, vecs[i].exp_ready);
      $display("txn fill%0d: wrote %02h level=%0d ovf=%0d", i, vecs[i].data, bus.level, bus.ovf);
    end
    idle_steps(5*FRAME + 1 - txd_log.size());
    for (int f = 0; f < 5; f++) begin
      logic [7:0] fb;
      fb = 8'(f + 1);
      check_frame($sformatf("burst_f%0d", f), 1 + f*FRAME, {1'b1, fb, 1'b0});
    end
    drain();
    $display("txn burst: five frames drained");

    // Push and pop on the same edge at the last stop cycle.
    txd_log.delete();
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    check("pp_level_pre", bus.level, 3'd2);
    idle_steps(FRAME - 2);
    check("pp_last_stop", txd_log[FRAME], 1'b1);
    step(1'b1, 8'h44);
    check("pp_level_same", bus.level, 3'd2);
    check("pp_start_nogap", TXD, 1'b0);
    drain();
    $display("txn pushpop: level held at 2");

    // Reset during data bit 3 of 0x3C.
    b3c = 8'h3C;
    txd_log.delete();
    step(1'b1, 8'h3C);
    step(1'b1, 8'h77);
    step(1'b1, 8'h88);
    idle_steps(16);
    check("mid_bit3", TXD, b3c[3]);
    check("mid_level", bus.level, 3'd2);
    RESETN = 1'b0;
    #1;
    check("mid_rst_txd",   TXD,       1'b1);
    check("mid_rst_level", bus.level, 3'd0);
    check("mid_rst_busy",  bus.busy,  1'b0);
    check("mid_rst_ovf",   bus.ovf,   1'b0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESETN = 1'b1;
    txd_log.delete();
    step(1'b1, 8'h55);
    idle_steps(FRAME);
    check_frame("post_rst_55", 1, 10'b1010101010);
    drain();
    $display("txn reset: mid-frame reset then clean 0x55");

    // 0x00 then 0xFF: long low run, short stop, short start, long high run.
    txd_log.delete();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    idle_steps(2*FRAME + 1 - txd_log.size());
    for (int i = 0; i < 2*FRAME; i++) begin
      logic e;
      e = (i < 36) ? 1'b0 : (i < 40) ? 1'b1 : (i < 44) ? 1'b0 : 1'b1;
      check($sformatf("runs_s%0d", i), txd_log[1 + i], e);
    end
    drain();
    $display("txn runs: 00/FF run lengths");

    // Randomised writes against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic we;
      we = ($urandom_range(0, 99) < 12);
      step(we, 8'($urandom));
    end
    drain();
    $display("txn random: 600 cycles");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
